// File: rtl/pw_trigger_seq.sv
// Armed one-shot trigger sequencer: waits for a match strobe, then a programmable
// delay, then drives a programmable train of trigger pulses.
module pw_trigger_seq #(
    parameter int unsigned pDELAY_WIDTH = 20,
    parameter int unsigned pWIDTH_WIDTH = 17,
    parameter int unsigned pNUM_WIDTH   = 4
) (
    input  logic                    trigger_clk,
    input  logic                    reset_i,
    input  logic                    I_arm,
    input  logic                    I_disarm,
    input  logic                    I_match,
    input  logic [pDELAY_WIDTH-1:0] I_delay,
    input  logic [pWIDTH_WIDTH-1:0] I_width,
    input  logic [pDELAY_WIDTH-1:0] I_gap,
    input  logic [pNUM_WIDTH-1:0]   I_num_pulses,
    output logic                    O_trigger,
    output logic                    O_armed,
    output logic                    O_busy,
    output logic                    O_done
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        PULSE,
        GAP
    } state_t;

    state_t                  state;
    logic [pDELAY_WIDTH-1:0] delay_r;
    logic [pDELAY_WIDTH-1:0] gap_r;
    logic [pWIDTH_WIDTH-1:0] wlast_r;
    logic [pNUM_WIDTH-1:0]   num_r;
    logic [pDELAY_WIDTH-1:0] cnt;
    logic [pWIDTH_WIDTH-1:0] wcnt;
    logic [pNUM_WIDTH-1:0]   pcnt;
    logic                    done_pend;

    // O_trigger and O_done lag the state by one cycle; O_armed/O_busy follow the state directly.
    always_ff @(posedge trigger_clk or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            delay_r   <= '0;
            gap_r     <= '0;
            wlast_r   <= '0;
            num_r     <= '0;
            cnt       <= '0;
            wcnt      <= '0;
            pcnt      <= '0;
            done_pend <= 1'b0;
            O_trigger <= 1'b0;
            O_armed   <= 1'b0;
            O_busy    <= 1'b0;
            O_done    <= 1'b0;
        end else begin
            O_trigger <= (state == PULSE) && !I_disarm;
            O_done    <= done_pend;
            done_pend <= 1'b0;
            if (I_disarm && (state != IDLE)) begin
                state   <= IDLE;
                O_armed <= 1'b0;
                O_busy  <= 1'b0;
                cnt     <= '0;
                wcnt    <= '0;
                pcnt    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        // Arming is held off until the completion strobe has been seen.
                        if (I_arm && !I_disarm && !done_pend && !O_done) begin
                            delay_r <= I_delay;
                            gap_r   <= I_gap;
                            wlast_r <= (I_width == '0) ? '0 : I_width - pWIDTH_WIDTH'(1);
                            num_r   <= I_num_pulses;
                            state   <= ARMED;
                            O_armed <= 1'b1;
                        end
                    end
                    ARMED: begin
                        if (I_match) begin
                            cnt     <= '0;
                            wcnt    <= '0;
                            pcnt    <= '0;
                            O_armed <= 1'b0;
                            O_busy  <= 1'b1;
                            state   <= (delay_r == '0) ? PULSE : DELAY;
                        end
                    end
                    DELAY: begin
                        if (cnt == delay_r - pDELAY_WIDTH'(1)) begin
                            wcnt  <= '0;
                            state <= PULSE;
                        end else begin
                            cnt <= cnt + pDELAY_WIDTH'(1);
                        end
                    end
                    PULSE: begin
                        if (wcnt == wlast_r) begin
                            if (pcnt == num_r) begin
                                state     <= IDLE;
                                O_busy    <= 1'b0;
                                done_pend <= 1'b1;
                            end else begin
                                cnt   <= '0;
                                pcnt  <= pcnt + pNUM_WIDTH'(1);
                                state <= GAP;
                            end
                        end else begin
                            wcnt <= wcnt + pWIDTH_WIDTH'(1);
                        end
                    end
                    GAP: begin
                        if (cnt == gap_r) begin
                            wcnt  <= '0;
                            state <= PULSE;
                        end else begin
                            cnt <= cnt + pDELAY_WIDTH'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pw_trigger_seq.sv
// Directed and randomized checks of pw_trigger_seq against a timing-formula reference model.
module tb_pw_trigger_seq;

    logic        trigger_clk = 1'b0;
    logic        reset_i     = 1'b1;
    logic        I_arm       = 1'b0;
    logic        I_disarm    = 1'b0;
    logic        I_match     = 1'b0;
    logic [19:0] I_delay     = '0;
    logic [16:0] I_width     = '0;
    logic [19:0] I_gap       = '0;
    logic [3:0]  I_num_pulses = '0;
    logic        O_trigger, O_armed, O_busy, O_done;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 trigger_clk = ~trigger_clk;

    pw_trigger_seq dut (
        .trigger_clk (trigger_clk),
        .reset_i     (reset_i),
        .I_arm       (I_arm),
        .I_disarm    (I_disarm),
        .I_match     (I_match),
        .I_delay     (I_delay),
        .I_width     (I_width),
        .I_gap       (I_gap),
        .I_num_pulses(I_num_pulses),
        .O_trigger   (O_trigger),
        .O_armed     (O_armed),
        .O_busy      (O_busy),
        .O_done      (O_done)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic t, input logic a, input logic b, input logic d);
        chk({tag, ".trigger"}, O_trigger, t);
        chk({tag, ".armed"}, O_armed, a);
        chk({tag, ".busy"}, O_busy, b);
        chk({tag, ".done"}, O_done, d);
    endtask

    // Arm with the given settings, then scramble the setting inputs (they must be shadowed).
    task automatic arm(input int d, input int w, input int g, input int np, input bit scramble);
        @(negedge trigger_clk);
        I_delay      = 20'(d);
        I_width      = 17'(w);
        I_gap        = 20'(g);
        I_num_pulses = 4'(np);
        I_arm        = 1'b1;
        @(negedge trigger_clk);
        I_arm = 1'b0;
        chk_all("arm", 1'b0, 1'b1, 1'b0, 1'b0);
        if (scramble) begin
            I_delay      = 20'($urandom_range(0, 40));
            I_width      = 17'($urandom_range(0, 40));
            I_gap        = 20'($urandom_range(0, 40));
            I_num_pulses = 4'($urandom_range(0, 15));
        end
    endtask

    // Match, then compare every cycle with the closed-form pulse timeline.
    // dis_at >= 0 raises I_disarm at that relative negedge; arm_dly pokes I_arm during DELAY.
    task automatic fire(input string tag, input int d, input int w, input int g, input int np,
                        input int dis_at, input bit arm_dly);
        int we, n, len, s;
        logic et, eb, ed;
        we  = (w == 0) ? 1 : w;
        n   = np + 1;
        len = 1 + d + n * we + (n - 1) * (g + 1);
        repeat ($urandom_range(0, 3)) begin
            @(negedge trigger_clk);
            chk_all({tag, ".wait"}, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        I_match = 1'b1;
        for (int k = 0; k <= len + 2; k++) begin
            @(negedge trigger_clk);
            I_match  = 1'($urandom_range(0, 1));
            I_arm    = 1'b0;
            I_disarm = 1'b0;
            et = 1'b0;
            for (int p = 0; p < n; p++) begin
                s = 1 + d + p * (we + g + 1);
                if (k >= s && k < s + we) et = 1'b1;
            end
            ed = (k == len);
            eb = (k <= len - 2);
            if (dis_at >= 0 && k > dis_at) begin
                et = 1'b0;
                ed = 1'b0;
                eb = 1'b0;
            end
            chk_all(tag, et, 1'b0, eb, ed);
            if (k == dis_at) I_disarm = 1'b1;
            if (arm_dly && k == 0 && d >= 2) I_arm = 1'b1;
            if (dis_at < 0 && k == len) I_arm = 1'b1;
        end
        I_match = 1'b0;
        I_arm   = 1'b0;
    endtask

    task automatic match_ignored(input string tag);
        repeat (3) begin
            @(negedge trigger_clk);
            I_match = 1'b1;
            @(negedge trigger_clk);
            chk_all(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        I_match = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge trigger_clk);
        reset_i = 1'b0;
        match_ignored("post_reset_match");

        // Asynchronous reset while the trigger is high
        arm(2, 20, 0, 0, 1'b1);
        I_match = 1'b1;
        @(negedge trigger_clk);
        I_match = 1'b0;
        repeat (5) @(negedge trigger_clk);
        chk("pre_reset.trigger", O_trigger, 1'b1);
        #3 reset_i = 1'b1;
        #1 chk_all("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge trigger_clk);
        reset_i = 1'b0;
        match_ignored("after_async_reset");

        // Single pulse, train, disarm in gap
        arm(0, 1, 0, 0, 1'b1);
        fire("single", 0, 1, 0, 0, -1, 1'b0);
        arm(5, 3, 2, 2, 1'b1);
        fire("train", 5, 3, 2, 2, -1, 1'b0);
        arm(5, 3, 2, 2, 1'b1);
        fire("disarm_gap", 5, 3, 2, 2, 10, 1'b0);
        match_ignored("after_disarm");

        // Shadowing of the width setting
        arm(1, 4, 1, 0, 1'b0);
        I_width = 17'd9;
        fire("shadow_w4", 1, 4, 1, 0, -1, 1'b0);
        arm(1, 9, 1, 0, 1'b0);
        fire("shadow_w9", 1, 9, 1, 0, -1, 1'b0);

        // Edge cases: zero width, arm+disarm in IDLE, arm during DELAY, disarm mid-pulse
        arm(3, 0, 1, 1, 1'b1);
        fire("width0", 3, 0, 1, 1, -1, 1'b0);
        @(negedge trigger_clk);
        I_arm    = 1'b1;
        I_disarm = 1'b1;
        @(negedge trigger_clk);
        I_arm    = 1'b0;
        I_disarm = 1'b0;
        chk_all("arm_disarm_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        match_ignored("arm_disarm_idle_match");
        arm(6, 2, 1, 1, 1'b1);
        fire("arm_in_delay", 6, 2, 1, 1, -1, 1'b1);
        arm(2, 6, 1, 1, 1'b1);
        fire("disarm_pulse", 2, 6, 1, 1, 5, 1'b0);

        // Randomized sequences
        for (int i = 0; i < 15; i++) begin
            int d, w, g, np, dis;
            d   = $urandom_range(0, 12);
            w   = $urandom_range(0, 6);
            g   = $urandom_range(0, 5);
            np  = $urandom_range(0, 3);
            dis = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : -1;
            arm(d, w, g, np, 1'b1);
            fire("random", d, w, g, np, dis, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
